// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants for the debug dump streamer
// Purpose: FSM state encoding, dump-selection codes, default frame headers
//          and the bytes-per-word derivation used by the streamer and its
//          serializer.
// Ports:   none (package).
package debug_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HEADER   = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
  localparam logic [2:0] ST_CHECKSUM = 3'd3;
  localparam logic [2:0] ST_NEXT     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_REG  = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  localparam logic [7:0] HEADER_REG_DEFAULT = 8'hA1;
  localparam logic [7:0] HEADER_MEM_DEFAULT = 8'hA2;

  function automatic int bytes_per_word(input int word_size, input int uart_bus_size);
    return word_size / uart_bus_size;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - splits one word into UART-sized bytes, LSB first
// Purpose: presents the current byte of a word; on each advance strobe the next
//          byte is selected. The byte-0 slot is taken straight from word_in and
//          the rest of the word is captured at that moment, so upstream only has
//          to hold the word until its first byte goes out.
// Ports:   clk, rst (async, active-high), clear (return to byte 0),
//          advance (current byte consumed), word_in (word being sent),
//          byte_out (current byte), last (current byte is the word's last).
module word_byte_serializer
  import debug_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int UART_BUS_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  input  logic [WORD_SIZE-1:0]     word_in,
  output logic [UART_BUS_SIZE-1:0] byte_out,
  output logic                     last
);

  localparam int BPW = bytes_per_word(WORD_SIZE, UART_BUS_SIZE);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BPW - 1);

  logic [WORD_SIZE-1:0] shreg;
  logic [BW-1:0]        idx;

  assign byte_out = (idx == '0) ? word_in[UART_BUS_SIZE-1:0] : shreg[UART_BUS_SIZE-1:0];
  assign last     = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (advance) begin
      // Byte 0 is consumed from word_in, so the remainder is captured pre-shifted.
      shreg <= ((idx == '0) ? word_in : shreg) >> UART_BUS_SIZE;
      idx   <= last ? '0 : idx + BW'(1);
    end
  end

endmodule

// File: rtl/debug_dump_streamer.sv
// rtl/debug_dump_streamer.sv - frames register/memory dumps into the UART TX FIFO
// Purpose: on a start pulse, emits a register frame, a memory frame, or both,
//          each as header, payload bytes (word 0 first, LSB first) and an
//          optional XOR checksum of the payload, one byte per cycle whenever the
//          FIFO is not full.
// Ports:   i_clk, i_reset (async, active-high), i_start, i_abort, i_sel,
//          i_uart_full, i_registers, i_memory (inputs);
//          o_uart_wr, o_uart_data_wr, o_busy, o_done (registered outputs).
module debug_dump_streamer
  import debug_pkg::*;
#(
  parameter int                       UART_BUS_SIZE = 8,
  parameter int                       WORD_SIZE     = 32,
  parameter int                       REG_COUNT     = 32,
  parameter int                       MEM_COUNT     = 32,
  parameter logic [UART_BUS_SIZE-1:0] HEADER_REG    = HEADER_REG_DEFAULT,
  parameter logic [UART_BUS_SIZE-1:0] HEADER_MEM    = HEADER_MEM_DEFAULT,
  parameter bit                       CHECKSUM_EN   = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [1:0]                     i_sel,
  input  logic                           i_uart_full,
  input  logic [REG_COUNT*WORD_SIZE-1:0] i_registers,
  input  logic [MEM_COUNT*WORD_SIZE-1:0] i_memory,
  output logic                           o_uart_wr,
  output logic [UART_BUS_SIZE-1:0]       o_uart_data_wr,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int MAX_COUNT = (REG_COUNT > MEM_COUNT) ? REG_COUNT : MEM_COUNT;
  localparam int WW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [WW-1:0] REG_LAST = WW'(REG_COUNT - 1);
  localparam logic [WW-1:0] MEM_LAST = WW'(MEM_COUNT - 1);

  logic [2:0]               state;
  logic [1:0]               sel_q;
  logic                     mem_frame;
  logic [WW-1:0]            widx;
  logic [UART_BUS_SIZE-1:0] checksum;
  logic [WORD_SIZE-1:0]     reg_word;
  logic [WORD_SIZE-1:0]     mem_word;
  logic [UART_BUS_SIZE-1:0] payload_byte;
  logic                     ser_last;
  logic                     ser_advance;

  always_comb begin
    reg_word = '0;
    for (int k = 0; k < REG_COUNT; k++)
      if (widx == WW'(k)) reg_word = i_registers[k*WORD_SIZE +: WORD_SIZE];
  end

  always_comb begin
    mem_word = '0;
    for (int k = 0; k < MEM_COUNT; k++)
      if (widx == WW'(k)) mem_word = i_memory[k*WORD_SIZE +: WORD_SIZE];
  end

  assign ser_advance = (state == ST_PAYLOAD) && !i_abort && !i_uart_full;

  word_byte_serializer #(
    .WORD_SIZE    (WORD_SIZE),
    .UART_BUS_SIZE(UART_BUS_SIZE)
  ) u_serializer (
    .clk     (i_clk),
    .rst     (i_reset),
    .clear   (i_abort),
    .advance (ser_advance),
    .word_in (mem_frame ? mem_word : reg_word),
    .byte_out(payload_byte),
    .last    (ser_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      sel_q          <= SEL_NONE;
      mem_frame      <= 1'b0;
      widx           <= '0;
      checksum       <= '0;
      o_uart_wr      <= 1'b0;
      o_uart_data_wr <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_uart_wr <= 1'b0;
      o_done    <= 1'b0;
      if (i_abort) begin
        // Abort beats both a pending FIFO write and a start request.
        state  <= ST_IDLE;
        widx   <= '0;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start && i_sel != SEL_NONE) begin
              state     <= ST_HEADER;
              sel_q     <= i_sel;
              mem_frame <= (i_sel == SEL_MEM);
              o_busy    <= 1'b1;
            end
          end
          ST_HEADER: begin
            if (!i_uart_full) begin
              o_uart_wr      <= 1'b1;
              o_uart_data_wr <= mem_frame ? HEADER_MEM : HEADER_REG;
              checksum       <= '0;
              state          <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (!i_uart_full) begin
              o_uart_wr      <= 1'b1;
              o_uart_data_wr <= payload_byte;
              checksum       <= checksum ^ payload_byte;
              if (ser_last) begin
                if (widx == (mem_frame ? MEM_LAST : REG_LAST)) begin
                  widx  <= '0;
                  state <= CHECKSUM_EN ? ST_CHECKSUM : ST_NEXT;
                end else begin
                  widx <= widx + WW'(1);
                end
              end
            end
          end
          ST_CHECKSUM: begin
            if (!i_uart_full) begin
              o_uart_wr      <= 1'b1;
              o_uart_data_wr <= checksum;
              state          <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (sel_q == SEL_BOTH && !mem_frame) begin
              mem_frame <= 1'b1;
              state     <= ST_HEADER;
            end else begin
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_dump_streamer.sv
// tb/tb_debug_dump_streamer.sv - scoreboard bench for debug_dump_streamer
module tb_debug_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, abort_s, uart_full;
  logic [1:0]  sel;
  logic [1023:0] regs_bus, mem_bus;
  logic        wr, busy, done;
  logic [7:0]  data;

  logic        start2;
  logic [1:0]  sel2;
  logic [63:0] regs2_bus, mem2_bus;
  logic        wr2, busy2, done2;
  logic [7:0]  data2;

  debug_dump_streamer dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort_s), .i_sel(sel),
    .i_uart_full(uart_full), .i_registers(regs_bus), .i_memory(mem_bus),
    .o_uart_wr(wr), .o_uart_data_wr(data), .o_busy(busy), .o_done(done)
  );

  debug_dump_streamer #(.WORD_SIZE(16), .REG_COUNT(4), .MEM_COUNT(4), .CHECKSUM_EN(1'b0)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .i_abort(1'b0), .i_sel(sel2),
    .i_uart_full(1'b0), .i_registers(regs2_bus), .i_memory(mem2_bus),
    .o_uart_wr(wr2), .o_uart_data_wr(data2), .o_busy(busy2), .o_done(done2)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int wr_cnt = 0, wr2_cnt = 0, done_cnt = 0, done2_cnt = 0;
  int wr_base = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic full_s = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_s <= uart_full;
  end

  // Scoreboard monitor: pops one expected byte per observed FIFO write.
  always @(negedge clk) begin
    if (full_s) chk("no_write_during_stall", wr, 0);
    if (wr) begin
      if (wr_cnt == wr_base) first_wr_cyc = cyc;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got %0h expected none", data);
      end else chk("byte", data, exp_q.pop_front());
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (wr2) begin
      wr2_cnt++;
      if (exp2_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write2: got %0h expected none", data2);
      end else chk("byte2", data2, exp2_q.pop_front());
    end
    if (done2) done2_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input bit is_mem);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    exp_q.push_back(is_mem ? 8'hA2 : 8'hA1);
    for (int k = 0; k < 32; k++) begin
      w = is_mem ? mem_bus[k*32 +: 32] : regs_bus[k*32 +: 32];
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(w[j*8 +: 8]);
        cs ^= w[j*8 +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic start_dump(input logic [1:0] s, output int sc);
    sel     = s;
    start   = 1'b1;
    sc      = cyc + 1;
    wr_base = wr_cnt;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin step(); k++; end
    chk("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin step(); k++; end
    chk("write_timeout", wr_cnt >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, d0, base, dc;
    rst = 1'b1; start = 0; abort_s = 0; uart_full = 0; sel = 2'b00;
    start2 = 0; sel2 = 2'b00;
    for (int k = 0; k < 32; k++) begin
      regs_bus[k*32 +: 32] = 32'(k);
      mem_bus[k*32 +: 32]  = 32'hDEAD0000 + 32'(k);
    end
    regs2_bus = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    mem2_bus  = 64'h0;
    repeat (3) step();
    chk("reset_wr", wr, 0);
    chk("reset_data", data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    step();

    // Register dump, no stalls
    push_frame(1'b0);
    start_dump(2'b01, sc);
    chk("busy_after_start", busy, 1);
    wait_done(done_cnt + 1, 400);
    chk("reg_write_count", wr_cnt - wr_base, 130);
    chk("first_write_latency", first_wr_cyc - sc, 1);
    chk("done_after_last", done_cyc - last_wr_cyc, 2);
    chk("busy_with_done", busy, 0);
    chk("reg_queue_empty", exp_q.size(), 0);
    d0 = done_cyc - sc;
    chk("reg_duration", d0, 132);
    step();

    // Registers then memory
    push_frame(1'b0);
    push_frame(1'b1);
    start_dump(2'b11, sc);
    wait_done(done_cnt + 1, 800);
    chk("both_write_count", wr_cnt - wr_base, 260);
    chk("both_queue_empty", exp_q.size(), 0);
    chk("both_duration", done_cyc - sc, 263);
    step();

    // Five-cycle FIFO-full stall after the 10th byte
    push_frame(1'b0);
    start_dump(2'b01, sc);
    wait_writes(wr_base + 10, 50);
    uart_full = 1'b1;
    repeat (5) step();
    uart_full = 1'b0;
    wait_done(done_cnt + 1, 400);
    chk("stall_write_count", wr_cnt - wr_base, 130);
    chk("stall_duration", done_cyc - sc, d0 + 5);
    chk("stall_queue_empty", exp_q.size(), 0);
    step();

    // Abort at byte 50, then a fresh frame
    push_frame(1'b0);
    dc = done_cnt;
    start_dump(2'b01, sc);
    wait_writes(wr_base + 50, 100);
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    chk("abort_wr", wr, 0);
    chk("abort_busy", busy, 0);
    repeat (20) step();
    chk("abort_write_count", wr_cnt - wr_base, 50);
    chk("abort_no_done", done_cnt, dc);
    exp_q.delete();
    push_frame(1'b0);
    start_dump(2'b01, sc);
    wait_done(done_cnt + 1, 400);
    chk("post_abort_write_count", wr_cnt - wr_base, 130);
    chk("post_abort_queue_empty", exp_q.size(), 0);
    step();

    // Start with sel=00 is ignored
    start_dump(2'b00, sc);
    chk("sel_none_busy", busy, 0);
    repeat (10) step();
    chk("sel_none_writes", wr_cnt - wr_base, 0);

    // Second start while busy is ignored
    push_frame(1'b0);
    start_dump(2'b01, sc);
    base = wr_base;
    wait_writes(base + 20, 60);
    sel = 2'b10; start = 1'b1;
    step();
    start = 1'b0; sel = 2'b01;
    wait_done(done_cnt + 1, 400);
    chk("restart_write_count", wr_cnt - base, 130);
    chk("restart_duration", done_cyc - sc, 132);
    chk("restart_queue_empty", exp_q.size(), 0);
    step();

    // Asynchronous reset mid-payload
    push_frame(1'b0);
    dc = done_cnt;
    start_dump(2'b01, sc);
    wait_writes(wr_base + 40, 80);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_wr", wr, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_data", data, 0);
    chk("async_reset_done", done, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    base = wr_cnt;
    repeat (15) step();
    chk("post_reset_writes", wr_cnt - base, 0);
    chk("post_reset_no_done", done_cnt, dc);

    // Narrow configuration: 16-bit words, 4 registers, no checksum
    exp2_q = '{8'hA1, 8'h23, 8'h01, 8'h67, 8'h45, 8'hAB, 8'h89, 8'hEF, 8'hCD};
    base = wr2_cnt;
    dc = done2_cnt;
    sel2 = 2'b01; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 40 && done2_cnt == dc; k++) step();
    chk("small_done", done2_cnt, dc + 1);
    chk("small_write_count", wr2_cnt - base, 9);
    chk("small_queue_empty", exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
